// File: rtl/vga_color_sequencer.sv
// Frame-synchronous VGA test-colour sequencer: steps through a fixed 5-entry palette,
// or shows the sw colour when the SW_MANUAL_EN macro is defined and mode=1.
module vga_color_sequencer #(
  parameter int HOLD_FRAMES = 60
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        video_on,
  input  logic        mode,
  input  logic        pause,
  input  logic [11:0] sw,
  output logic [11:0] rgb,
  output logic [2:0]  color_idx,
  output logic        seq_done
);

  localparam int         DATA_W   = 12;
  localparam logic [7:0] LAST_CNT = 8'(HOLD_FRAMES - 1);
  localparam logic [2:0] LAST_IDX = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    AUTO   = 2'd1,
    PAUSED = 2'd2,
    MANUAL = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [7:0]          frame_cnt, cnt_n;
  logic [2:0]          idx_n;
  logic [DATA_W-1:0]   color_reg, color_n;
  logic                done_n;
  logic [DATA_W-1:0]   rgb_p1;
  logic                mode_en;
  logic [DATA_W-1:0]   sw_sel;

`ifdef SW_MANUAL_EN
  assign mode_en = mode;
  assign sw_sel  = sw;
`else
  // Manual path compiled out: mode and sw have no effect.
  assign mode_en = 1'b0;
  assign sw_sel  = '0;
  wire unused_manual = ^{mode, sw};
`endif

  function automatic logic [DATA_W-1:0] palette(input logic [2:0] idx);
    logic [DATA_W-1:0] c;
    case (idx)
      3'd1:    c = 12'h00F;
      3'd2:    c = 12'h0F0;
      3'd3:    c = 12'hF00;
      3'd4:    c = 12'hFFF;
      default: c = 12'h000;
    endcase
    return c;
  endfunction

  // Everything below only moves on frame_tick so the picture never tears mid-frame.
  always_comb begin
    state_n = state;
    cnt_n   = frame_cnt;
    idx_n   = color_idx;
    color_n = color_reg;
    done_n  = 1'b0;
    if (frame_tick) begin
      case (state)
        IDLE: begin
          if (mode_en) begin
            state_n = MANUAL;
            color_n = sw_sel;
          end else begin
            state_n = AUTO;
            color_n = palette(color_idx);
          end
        end
        AUTO: begin
          if (mode_en) begin
            state_n = MANUAL;
            color_n = sw_sel;
          end else if (pause) begin
            state_n = PAUSED;
            color_n = palette(color_idx);
          end else begin
            if (frame_cnt == LAST_CNT) begin
              cnt_n = '0;
              if (color_idx == LAST_IDX) begin
                idx_n  = '0;
                done_n = 1'b1;
              end else begin
                idx_n = color_idx + 3'd1;
              end
            end else begin
              cnt_n = frame_cnt + 8'd1;
            end
            color_n = palette(idx_n);
          end
        end
        PAUSED: begin
          if (mode_en) begin
            state_n = MANUAL;
            color_n = sw_sel;
          end else begin
            if (!pause) state_n = AUTO;
            color_n = palette(color_idx);
          end
        end
`ifdef SW_MANUAL_EN
        MANUAL: begin
          color_n = sw_sel;
          if (!mode_en) begin
            state_n = AUTO;
            cnt_n   = '0;
          end
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      frame_cnt <= '0;
      color_idx <= '0;
      color_reg <= '0;
      seq_done  <= 1'b0;
    end else begin
      state     <= state_n;
      frame_cnt <= cnt_n;
      color_idx <= idx_n;
      color_reg <= color_n;
      seq_done  <= done_n;
    end
  end

  // Output stage: blanking applied one clock after video_on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rgb_p1 <= '0;
    else        rgb_p1 <= video_on ? color_reg : '0;
  end

  assign rgb = rgb_p1;

endmodule

// File: tb/tb_vga_color_sequencer.sv
// Directed bench for vga_color_sequencer with HOLD_FRAMES=2; covers both SW_MANUAL_EN builds.
module tb_vga_color_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        video_on = 1'b0;
  logic        mode = 1'b0;
  logic        pause = 1'b0;
  logic [11:0] sw = 12'h000;
  logic [11:0] rgb;
  logic [2:0]  color_idx;
  logic        seq_done;

  int n_chk  = 0;
  int n_fail = 0;

  vga_color_sequencer #(.HOLD_FRAMES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .video_on   (video_on),
    .mode       (mode),
    .pause      (pause),
    .sw         (sw),
    .rgb        (rgb),
    .color_idx  (color_idx),
    .seq_done   (seq_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        vid;
    logic        md;
    logic        ps;
    logic [11:0] s;
    logic [2:0]  eidx;
    logic [11:0] ergb;
    logic        edone;
  } vec_t;

  vec_t tbl [21];

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One frame: a single-cycle tick, then settle one more clock for rgb.
  task automatic apply(input string nm, input logic vid, input logic md, input logic ps,
                       input logic [11:0] s, input logic [2:0] eidx,
                       input logic [11:0] ergb, input logic edone);
    video_on   = vid;
    mode       = md;
    pause      = ps;
    sw         = s;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    check({nm, ".idx"}, {9'b0, color_idx}, {9'b0, eidx});
    check({nm, ".done"}, {11'b0, seq_done}, {11'b0, edone});
    @(posedge clk);
    #1;
    check({nm, ".rgb"}, rgb, ergb);
    if (edone) check({nm, ".done_end"}, {11'b0, seq_done}, 12'h000);
  endtask

  initial begin
    // idx sequence from IDLE: IDLE tick, then 0,1,1,2,2,3,3,4,4,0 (wrap), then pause window
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 12'h000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 12'h000, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd1, 12'h00F, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd1, 12'h00F, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd2, 12'h0F0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd2, 12'h0F0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd3, 12'hF00, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd3, 12'hF00, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd4, 12'hFFF, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd4, 12'hFFF, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 12'h000, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 12'h000, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd1, 12'h00F, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd1, 12'h00F, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd2, 12'h0F0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd2, 12'h0F0, 1'b0};
    tbl[16] = '{1'b1, 1'b0, 1'b1, 12'h000, 3'd2, 12'h0F0, 1'b0};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 12'h000, 3'd2, 12'h0F0, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b1, 12'h000, 3'd2, 12'h0F0, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd2, 12'h0F0, 1'b0};
    tbl[20] = '{1'b1, 1'b0, 1'b0, 12'h000, 3'd3, 12'hF00, 1'b0};

    // Reset state, then idle in IDLE without ticks
    #2 reset = 1'b0;
    #1;
    check("rst.rgb", rgb, 12'h000);
    check("rst.idx", {9'b0, color_idx}, 12'h000);
    check("rst.done", {11'b0, seq_done}, 12'h000);
    repeat (3) @(posedge clk);
    #5 reset = 1'b1;
    video_on = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("idle.rgb", rgb, 12'h000);
    check("idle.idx", {9'b0, color_idx}, 12'h000);

    for (int i = 0; i < 21; i++)
      apply($sformatf("row%0d", i), tbl[i].vid, tbl[i].md, tbl[i].ps, tbl[i].s,
            tbl[i].eidx, tbl[i].ergb, tbl[i].edone);

    // frame_tick held two cycles acts twice: idx3 cnt0 -> cnt1 -> idx4
    frame_tick = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    check("hold2.idx", {9'b0, color_idx}, 12'h004);
    check("hold2.done", {11'b0, seq_done}, 12'h000);
    @(posedge clk);
    #1;
    check("hold2.rgb", rgb, 12'hFFF);

    // Blanking latency
    video_on = 1'b0;
    #1;
    check("vid0.pre", rgb, 12'hFFF);
    @(posedge clk);
    #1;
    check("vid0.post", rgb, 12'h000);
    video_on = 1'b1;
    @(posedge clk);
    #1;
    check("vid1.post", rgb, 12'hFFF);

    // pause pulsed between ticks must not register
    pause = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pause = 1'b0;
    apply("midpause", 1'b1, 1'b0, 1'b0, 12'h000, 3'd4, 12'hFFF, 1'b0);
    apply("wrap2",    1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 12'h000, 1'b1);

    // Walk to idx3 and assert reset between clock edges
    apply("w0", 1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 12'h000, 1'b0);
    apply("w1", 1'b1, 1'b0, 1'b0, 12'h000, 3'd1, 12'h00F, 1'b0);
    apply("w2", 1'b1, 1'b0, 1'b0, 12'h000, 3'd1, 12'h00F, 1'b0);
    apply("w3", 1'b1, 1'b0, 1'b0, 12'h000, 3'd2, 12'h0F0, 1'b0);
    apply("w4", 1'b1, 1'b0, 1'b0, 12'h000, 3'd2, 12'h0F0, 1'b0);
    apply("w5", 1'b1, 1'b0, 1'b0, 12'h000, 3'd3, 12'hF00, 1'b0);
    apply("w6", 1'b1, 1'b0, 1'b0, 12'h000, 3'd3, 12'hF00, 1'b0);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst.rgb", rgb, 12'h000);
    check("arst.idx", {9'b0, color_idx}, 12'h000);
    #10 reset = 1'b1;
    @(posedge clk);
    #1;

`ifdef SW_MANUAL_EN
    mode = 1'b1;
    sw   = 12'hF00;
    repeat (3) @(posedge clk);
    #1;
    check("man.pre", rgb, 12'h000);
    apply("man0", 1'b1, 1'b1, 1'b0, 12'hF00, 3'd0, 12'hF00, 1'b0);
    sw = 12'hFFF;
    repeat (3) @(posedge clk);
    #1;
    check("man.swmid", rgb, 12'hF00);
    apply("man1", 1'b1, 1'b1, 1'b0, 12'hFFF, 3'd0, 12'hFFF, 1'b0);
    apply("mexit", 1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 12'h000, 1'b0);
    apply("ma0",  1'b1, 1'b0, 1'b0, 12'h000, 3'd0, 12'h000, 1'b0);
    apply("ma1",  1'b1, 1'b0, 1'b0, 12'h000, 3'd1, 12'h00F, 1'b0);
    apply("ma2",  1'b1, 1'b0, 1'b0, 12'h000, 3'd1, 12'h00F, 1'b0);
    apply("prio", 1'b1, 1'b1, 1'b1, 12'h0FF, 3'd1, 12'h0FF, 1'b0);
    apply("mexit2", 1'b1, 1'b0, 1'b0, 12'h00F, 3'd1, 12'h00F, 1'b0);
    apply("clr0", 1'b1, 1'b0, 1'b0, 12'h000, 3'd1, 12'h00F, 1'b0);
    apply("clr1", 1'b1, 1'b0, 1'b0, 12'h000, 3'd2, 12'h0F0, 1'b0);
`else
    mode = 1'b1;
    sw   = 12'hF00;
    repeat (3) @(posedge clk);
    #1;
    check("man.pre", rgb, 12'h000);
    apply("nm0", 1'b1, 1'b1, 1'b0, 12'hF00, 3'd0, 12'h000, 1'b0);
    apply("nm1", 1'b1, 1'b1, 1'b0, 12'hF00, 3'd0, 12'h000, 1'b0);
    apply("nm2", 1'b1, 1'b1, 1'b0, 12'hF00, 3'd1, 12'h00F, 1'b0);
    apply("np0", 1'b1, 1'b1, 1'b1, 12'hF00, 3'd1, 12'h00F, 1'b0);
    apply("np1", 1'b1, 1'b1, 1'b1, 12'hF00, 3'd1, 12'h00F, 1'b0);
    apply("nr0", 1'b1, 1'b0, 1'b0, 12'h000, 3'd1, 12'h00F, 1'b0);
    apply("nr1", 1'b1, 1'b0, 1'b0, 12'h000, 3'd1, 12'h00F, 1'b0);
    apply("nr2", 1'b1, 1'b0, 1'b0, 12'h000, 3'd2, 12'h0F0, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
